// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_pkg
//  Purpose  : Shared vertex record, terminator id and fetch FSM encoding.
//  Revision : 1.0
// ============================================================================
package gfx_pkg;

  localparam logic [11:0] TERMINATOR_ID = 12'hFFF;

  typedef struct packed {
    logic [11:0]      index_id;
    logic [2:0][31:0] position;
    logic [2:0][31:0] normal;
    logic [11:0]      material;
  } vertex_t;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_ISSUE = 2'd1,
    FS_DRAIN = 2'd2,
    FS_DONE  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vertex_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vertex_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO, power-of-2 depth.
//  Revision : 1.0
// ============================================================================
module vertex_fifo #(
  parameter int WIDTH = 216,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_AW-1:0]   c_PTR_ONE  = {{(c_AW-1){1'b0}}, 1'b1};
  localparam logic [c_AW:0]     c_CNT_ONE  = {{c_AW{1'b0}}, 1'b1};
  localparam logic [c_AW:0]     c_CNT_FULL = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == c_CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot in the same cycle, so push-on-full with pop is legal.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vertex_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vertex_fetch_scheduler
//  Purpose  : Per-frame index issue sequencer with credit flow control and
//             an output FIFO feeding the transform stage.
//  Revision : 1.0
// ============================================================================
module vertex_fetch_scheduler
  import gfx_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int FETCH_LATENCY = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int DATA_WIDTH    = 216
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  output logic [ADDR_WIDTH-1:0] index_addr_out,
  output logic                  index_en_out,
  input  logic                  fetch_valid_in,
  input  logic                  fetch_last_in,
  input  logic [DATA_WIDTH-1:0] fetch_data_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy_out,
  output logic                  frame_done_out
);

  localparam int                    c_CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_CW-1:0]       c_CREDITS  = FIFO_DEPTH[c_CW-1:0];
  localparam logic [c_CW-1:0]       c_CNT_ONE  = {{(c_CW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;

  localparam logic [1:0] c_IDLE  = FS_IDLE;
  localparam logic [1:0] c_ISSUE = FS_ISSUE;
  localparam logic [1:0] c_DRAIN = FS_DRAIN;
  localparam logic [1:0] c_DONE  = FS_DONE;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [c_CW-1:0]       r_in_flight;
  logic                  r_squash;

  logic            w_ret_live;
  logic            w_term;
  logic            w_push;
  logic            w_pop;
  logic            w_credit_ok;
  logic            w_issue;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [c_CW-1:0] w_fifo_count;

  // Returns arriving with nothing outstanding are leftovers from before a reset.
  assign w_ret_live  = fetch_valid_in && (r_in_flight != '0);
  assign w_term      = w_ret_live && fetch_last_in && !r_squash;
  assign w_push      = w_ret_live && !fetch_last_in && !r_squash;
  assign w_pop       = valid_out && ready_in;
  assign w_credit_ok = ({1'b0, r_in_flight} + {1'b0, w_fifo_count}) < {1'b0, c_CREDITS};
  assign w_issue     = (r_state == c_ISSUE) && w_credit_ok && !w_term;

  assign index_addr_out = r_addr;
  assign index_en_out   = w_issue;
  assign valid_out      = !w_fifo_empty;
  assign busy_out       = (r_state == c_ISSUE) || (r_state == c_DRAIN);
  assign frame_done_out = (r_state == c_DONE);

  vertex_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .i_push  (w_push),
    .i_data  (fetch_data_in),
    .i_pop   (w_pop),
    .o_data  (data_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_in_flight <= '0;
      r_squash    <= 1'b0;
    end else begin
      case ({w_issue, w_ret_live})
        2'b10:   r_in_flight <= r_in_flight + c_CNT_ONE;
        2'b01:   r_in_flight <= r_in_flight - c_CNT_ONE;
        default: r_in_flight <= r_in_flight;
      endcase

      case (r_state)
        c_IDLE: begin
          r_squash <= 1'b0;
          r_addr   <= '0;
          if (start_in) r_state <= c_ISSUE;
        end
        c_ISSUE: begin
          // The last index is held rather than wrapped; the frame ends there.
          if (w_issue && (r_addr != c_ADDR_MAX)) r_addr <= r_addr + c_ADDR_ONE;
          if (w_term || (w_issue && (r_addr == c_ADDR_MAX))) r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if ((r_in_flight == '0) && w_fifo_empty) r_state <= c_DONE;
        end
        default: r_state <= c_IDLE;
      endcase

      if (w_term) r_squash <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(w_push && w_fifo_full && !w_pop));
      assert ((FIFO_DEPTH >= FETCH_LATENCY) && (DATA_WIDTH == $bits(vertex_t)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vertex_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vertex_fetch_scheduler
//  Purpose  : Scoreboard bench with a fixed-latency index/vertex ROM model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vertex_fetch_scheduler;
  import gfx_pkg::*;

  localparam int AW    = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 216;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [AW-1:0] index_addr_out;
  logic          index_en_out;
  logic          fetch_valid_in;
  logic          fetch_last_in;
  logic [DW-1:0] fetch_data_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          busy_out;
  logic          frame_done_out;

  int n_tests = 0;
  int n_fail  = 0;
  int term_addr = -1;
  int exp_addr, n_issue, n_ret, n_beats, n_done, cyc, first_valid_cyc;
  int iss_cnt [16];
  bit seen_last;
  vertex_t sb [$];

  initial forever #5 clk = ~clk;

  vertex_fetch_scheduler #(
    .ADDR_WIDTH(AW), .FETCH_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .index_addr_out(index_addr_out), .index_en_out(index_en_out),
    .fetch_valid_in(fetch_valid_in), .fetch_last_in(fetch_last_in),
    .fetch_data_in(fetch_data_in), .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  function automatic vertex_t mk_vertex(input int a);
    vertex_t v;
    v.index_id = a[11:0];
    for (int i = 0; i < 3; i++) begin
      v.position[i] = 32'(a * 97 + i * 13 + 1);
      v.normal[i]   = 32'hC0DE_0000 ^ 32'(a << (i + 4));
    end
    v.material = 12'(a + 256);
    return v;
  endfunction

  // Datapath: each issued address returns exactly LAT cycles later.
  logic [AW:0] pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= {index_en_out, index_addr_out};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fetch_valid_in = pipe[LAT-1][AW];
  assign fetch_last_in  = fetch_valid_in && (int'(pipe[LAT-1][AW-1:0]) == term_addr);
  assign fetch_data_in  = mk_vertex(int'(pipe[LAT-1][AW-1:0]));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    vertex_t e;
    @(negedge clk);
    if (!rst_in) begin
      if (index_en_out) begin
        n_tests++;
        if (index_addr_out !== exp_addr[AW-1:0]) begin
          n_fail++;
          $display("FAIL issue_addr: got %0d expected %0d", index_addr_out, exp_addr);
        end
        exp_addr++;
        n_issue++;
        iss_cnt[index_addr_out]++;
        if (term_addr < 0 || int'(index_addr_out) < term_addr)
          sb.push_back(mk_vertex(int'(index_addr_out)));
      end
      if (fetch_valid_in) begin
        n_ret++;
        if (fetch_last_in) seen_last = 1'b1;
      end
      if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_out && ready_in) begin
        n_tests++;
        n_beats++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got index_id %0d expected no beat", data_out[DW-1 -: 12]);
        end else begin
          e = sb.pop_front();
          if (data_out !== e) begin
            n_fail++;
            $display("FAIL beat_data: got %h expected %h", data_out, e);
          end
        end
      end
      if (frame_done_out) n_done++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_frame(input int term);
    term_addr = term;
    exp_addr = 0; n_issue = 0; n_ret = 0; n_beats = 0; n_done = 0;
    first_valid_cyc = -1; seen_last = 1'b0;
    foreach (iss_cnt[i]) iss_cnt[i] = 0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      if (rand_ready) ready_in = 1'($urandom_range(0, 1));
      tick();
    end
    n_tests++;
    if (n_done == 0) begin
      n_fail++;
      $display("FAIL done_timeout: got no frame_done_out within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({index_en_out, index_addr_out, valid_out, busy_out, frame_done_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en=%b addr=%0d valid=%b busy=%b done=%b expected all 0",
               index_en_out, index_addr_out, valid_out, busy_out, frame_done_out);
    end
    n_tests++;
    if (data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", data_out);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int start_cyc;
    ready_in = 1'b1;
    start_frame(5);
    start_cyc = cyc;
    n_tests++;
    if (busy_out !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_out);
    end
    wait_done(300, 1'b0);
    repeat (6) tick();
    n_tests++;
    if (first_valid_cyc != start_cyc + LAT + 1) begin
      n_fail++;
      $display("FAIL basic_latency: got cycle %0d expected %0d", first_valid_cyc, start_cyc + LAT + 1);
    end
    n_tests++;
    if (n_beats != 5 || sb.size() != 0) begin
      n_fail++; $display("FAIL basic_beats: got %0d (left %0d) expected 5 (left 0)", n_beats, sb.size());
    end
    n_tests++;
    if (n_issue < 6) begin
      n_fail++; $display("FAIL basic_issues: got %0d expected >= 6", n_issue);
    end
    n_tests++;
    if (n_done != 1 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL basic_end: got done=%0d busy=%b expected done=1 busy=0", n_done, busy_out);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d_early;
    vertex_t v0;
    v0 = mk_vertex(0);
    d_early = '0;
    ready_in = 1'b0;
    start_frame(12);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 10) d_early = data_out;
    end
    n_tests++;
    if (n_issue != DEPTH || index_en_out !== 1'b0) begin
      n_fail++; $display("FAIL bp_issue: got %0d issues en=%b expected %0d en=0", n_issue, index_en_out, DEPTH);
    end
    n_tests++;
    if (valid_out !== 1'b1 || (n_ret - n_beats) != DEPTH) begin
      n_fail++; $display("FAIL bp_fill: got valid=%b held=%0d expected valid=1 held=%0d", valid_out, n_ret - n_beats, DEPTH);
    end
    n_tests++;
    if (d_early !== v0 || data_out !== v0) begin
      n_fail++; $display("FAIL bp_stable: got %h / %h expected %h", d_early, data_out, v0);
    end
    ready_in = 1'b1;
    wait_done(400, 1'b0);
    n_tests++;
    if (n_beats != 12 || sb.size() != 0 || n_done != 1) begin
      n_fail++; $display("FAIL bp_drain: got beats=%0d left=%0d done=%0d expected 12/0/1", n_beats, sb.size(), n_done);
    end
  endtask

  task automatic test_empty_frame();
    ready_in = 1'b1;
    start_frame(0);
    wait_done(200, 1'b0);
    repeat (4) tick();
    n_tests++;
    if (n_beats != 0 || n_done != 1) begin
      n_fail++; $display("FAIL empty_frame: got beats=%0d done=%0d expected 0/1", n_beats, n_done);
    end
    start_frame(3);
    wait_done(200, 1'b0);
    repeat (4) tick();
    n_tests++;
    if (n_beats != 3 || sb.size() != 0 || n_done != 1) begin
      n_fail++; $display("FAIL restart: got beats=%0d left=%0d done=%0d expected 3/0/1", n_beats, sb.size(), n_done);
    end
  endtask

  task automatic test_addr_wrap();
    ready_in = 1'b1;
    start_frame(-1);
    wait_done(400, 1'b0);
    repeat (4) tick();
    n_tests++;
    if (n_issue != 16 || n_beats != 16 || n_done != 1) begin
      n_fail++; $display("FAIL wrap_count: got issues=%0d beats=%0d done=%0d expected 16/16/1", n_issue, n_beats, n_done);
    end
    for (int a = 0; a < 16; a++) begin
      n_tests++;
      if (iss_cnt[a] != 1) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %0d issues expected 1", a, iss_cnt[a]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int guard;
    ready_in = 1'b0;
    start_frame(-1);
    guard = 0;
    while (!(n_issue == 8 && n_ret == 4) && guard < 50) begin
      tick();
      guard++;
    end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    rst_in = 1'b1;
    n_tests++;
    if ((n_issue - n_ret) != 3 || (n_ret - n_beats) != 4) begin
      n_fail++; $display("FAIL mid_setup: got in_flight=%0d held=%0d expected 3/4", n_issue - n_ret, n_ret - n_beats);
    end
    tick();
    n_tests++;
    if ({index_en_out, index_addr_out, valid_out, busy_out, frame_done_out} !== '0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got en=%b addr=%0d valid=%b busy=%b done=%b data=%h expected all 0",
               index_en_out, index_addr_out, valid_out, busy_out, frame_done_out, data_out);
    end
    rst_in = 1'b0;
    sb.delete();
    n_beats = 0; n_done = 0;
    ready_in = 1'b1;
    repeat (12) tick();
    n_tests++;
    if (n_beats != 0 || n_done != 0 || valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL mid_stale: got beats=%0d done=%0d valid=%b busy=%b expected 0/0/0/0",
                         n_beats, n_done, valid_out, busy_out);
    end
  endtask

  task automatic test_start_in_drain();
    bit pulsed;
    int issued;
    pulsed = 1'b0;
    start_frame(5);
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      ready_in = 1'($urandom_range(0, 1));
      tick();
      start_in = 1'b0;
      if (seen_last && !pulsed) begin
        pulsed = 1'b1;
        n_tests++;
        if (busy_out !== 1'b1) begin
          n_fail++; $display("FAIL drain_busy: got %b expected 1", busy_out);
        end
        start_in = 1'b1;
      end
    end
    start_in = 1'b0;
    n_tests++;
    if (n_done == 0 || !pulsed) begin
      n_fail++; $display("FAIL drain_timeout: got done=%0d pulsed=%b expected done and pulse", n_done, pulsed);
    end
    issued = n_issue;
    ready_in = 1'b1;
    repeat (10) tick();
    n_tests++;
    if (n_done != 1 || n_beats != 5 || sb.size() != 0 || busy_out !== 1'b0 || n_issue != issued) begin
      n_fail++; $display("FAIL drain_ignore: got done=%0d beats=%0d left=%0d busy=%b new_issues=%0d expected 1/5/0/0/0",
                         n_done, n_beats, sb.size(), busy_out, n_issue - issued);
    end
  endtask

  initial begin
    cyc = 0;
    exp_addr = 0; n_issue = 0; n_ret = 0; n_beats = 0; n_done = 0;
    first_valid_cyc = -1; seen_last = 1'b0;
    foreach (iss_cnt[i]) iss_cnt[i] = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_frame();
    test_addr_wrap();
    test_reset_midframe();
    test_start_in_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
